// File: rtl/interrupt_controller_if.sv
// CPU memory bus seen by the interrupt controller: 12-bit address, 4-bit data,
// separate read/write strobes and a registered read-data return path.
interface interrupt_controller_if;
    logic [11:0] bus_addr;
    logic        bus_write_en;
    logic        bus_read_en;
    logic [3:0]  bus_data_in;
    logic [3:0]  bus_data_out;
    logic        bus_data_valid;

    modport master (
        output bus_addr,
        output bus_write_en,
        output bus_read_en,
        output bus_data_in,
        input  bus_data_out,
        input  bus_data_valid
    );

    modport slave (
        input  bus_addr,
        input  bus_write_en,
        input  bus_read_en,
        input  bus_data_in,
        output bus_data_out,
        output bus_data_valid
    );
endinterface

// File: rtl/interrupt_controller.sv
// Interrupt controller: latches peripheral events into clear-on-read factor
// flags, gates them with software masks and drives a registered request vector.
// Optional feature macro: INT_INPUT_EDGE_EN (K inputs synchronized and
// rising-edge detected instead of being taken as ready-made pulses).
module interrupt_controller #(
    parameter logic [11:0] BASE_ADDR = 12'hF00
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clk_en,
    input  logic [3:0]                    timer_evt,
    input  logic [1:0]                    stopwatch_evt,
    input  logic                          prog_timer_evt,
    input  logic                          serial_evt,
    input  logic [3:0]                    input_k0,
    input  logic [3:0]                    input_k1,
    interrupt_controller_if.slave         bus,
    output logic [14:0]                   interrupt_req
);

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned REQ_W  = 15;
    localparam int unsigned K_W    = 8;

    // Factor flags
    logic [3:0] it_q,   it_d;
    logic [1:0] isw_q,  isw_d;
    logic       ipt_q,  ipt_d;
    logic       isio_q, isio_d;
    logic       ik0_q,  ik0_d;
    logic       ik1_q,  ik1_d;

    // Masks
    logic [3:0] eit_q,   eit_d;
    logic [1:0] eisw_q,  eisw_d;
    logic       eipt_q,  eipt_d;
    logic       eisio_q, eisio_d;
    logic [3:0] eik0_q,  eik0_d;
    logic [3:0] eik1_q,  eik1_d;

    // Registered outputs
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic [REQ_W-1:0]  req_q, req_d;

    // Address decode
    logic [ADDR_W-1:0] offs;
    logic              reg_hit;
    logic              is_mask;
    logic [2:0]        sel;
    logic              rd_fire;
    logic              wr_fire;
    logic [DATA_W-1:0] rd_data;
    logic [K_W-1:0]    k_pulse;

    assign offs    = bus.bus_addr - BASE_ADDR;
    assign reg_hit = (offs[ADDR_W-1:5] == '0) && !offs[3] && (offs[2:0] < 3'd6);
    assign is_mask = offs[4];
    assign sel     = offs[2:0];
    assign rd_fire = clk_en && bus.bus_read_en && reg_hit;
    assign wr_fire = clk_en && bus.bus_write_en && reg_hit && is_mask;

`ifdef INT_INPUT_EDGE_EN
    logic [K_W-1:0] sync1_q, sync2_q, prev_q;

    // Two-flop synchronizer plus previous-value register for rising-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else if (clk_en) begin
            sync1_q <= {input_k1, input_k0};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign k_pulse = sync2_q & ~prev_q;
`else
    assign k_pulse = {input_k1, input_k0};
`endif

    // Read-data multiplexer over the factor and mask registers; unused bits read 0
    always_comb begin
        rd_data = '0;
        case ({is_mask, sel})
            4'b0_000: rd_data = it_q;
            4'b0_001: rd_data = {2'b00, isw_q};
            4'b0_010: rd_data = {3'b000, ipt_q};
            4'b0_011: rd_data = {3'b000, isio_q};
            4'b0_100: rd_data = {3'b000, ik0_q};
            4'b0_101: rd_data = {3'b000, ik1_q};
            4'b1_000: rd_data = eit_q;
            4'b1_001: rd_data = {2'b00, eisw_q};
            4'b1_010: rd_data = {3'b000, eipt_q};
            4'b1_011: rd_data = {3'b000, eisio_q};
            4'b1_100: rd_data = eik0_q;
            4'b1_101: rd_data = eik1_q;
            default:  rd_data = '0;
        endcase
    end

    // Next-state: flag set/clear, mask writes, read return and request vector
    always_comb begin
        it_d         = it_q;
        isw_d        = isw_q;
        ipt_d        = ipt_q;
        isio_d       = isio_q;
        ik0_d        = ik0_q;
        ik1_d        = ik1_q;
        eit_d        = eit_q;
        eisw_d       = eisw_q;
        eipt_d       = eipt_q;
        eisio_d      = eisio_q;
        eik0_d       = eik0_q;
        eik1_d       = eik1_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        req_d        = req_q;

        if (clk_en) begin
            // Clear-on-read first, then OR in new events so a coincident event survives
            if (rd_fire && !is_mask) begin
                case (sel)
                    3'd0:    it_d   = '0;
                    3'd1:    isw_d  = '0;
                    3'd2:    ipt_d  = 1'b0;
                    3'd3:    isio_d = 1'b0;
                    3'd4:    ik0_d  = 1'b0;
                    3'd5:    ik1_d  = 1'b0;
                    default: ;
                endcase
            end
            it_d   = it_d | timer_evt;
            isw_d  = isw_d | stopwatch_evt;
            ipt_d  = ipt_d | prog_timer_evt;
            isio_d = isio_d | serial_evt;
            ik0_d  = ik0_d | (|(k_pulse[3:0] & eik0_q));
            ik1_d  = ik1_d | (|(k_pulse[7:4] & eik1_q));

            if (wr_fire) begin
                case (sel)
                    3'd0:    eit_d   = bus.bus_data_in;
                    3'd1:    eisw_d  = bus.bus_data_in[1:0];
                    3'd2:    eipt_d  = bus.bus_data_in[0];
                    3'd3:    eisio_d = bus.bus_data_in[0];
                    3'd4:    eik0_d  = bus.bus_data_in;
                    3'd5:    eik1_d  = bus.bus_data_in;
                    default: ;
                endcase
            end

            if (rd_fire) begin
                data_out_d   = rd_data;
                data_valid_d = 1'b1;
            end

            req_d = {8'b0,
                     |(it_q & eit_q),
                     |(isw_q & eisw_q),
                     ik0_q,
                     ik1_q,
                     isio_q & eisio_q,
                     ipt_q & eipt_q,
                     1'b0};
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            it_q         <= '0;
            isw_q        <= '0;
            ipt_q        <= 1'b0;
            isio_q       <= 1'b0;
            ik0_q        <= 1'b0;
            ik1_q        <= 1'b0;
            eit_q        <= '0;
            eisw_q       <= '0;
            eipt_q       <= 1'b0;
            eisio_q      <= 1'b0;
            eik0_q       <= '0;
            eik1_q       <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            req_q        <= '0;
        end else begin
            it_q         <= it_d;
            isw_q        <= isw_d;
            ipt_q        <= ipt_d;
            isio_q       <= isio_d;
            ik0_q        <= ik0_d;
            ik1_q        <= ik1_d;
            eit_q        <= eit_d;
            eisw_q       <= eisw_d;
            eipt_q       <= eipt_d;
            eisio_q      <= eisio_d;
            eik0_q       <= eik0_d;
            eik1_q       <= eik1_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            req_q        <= req_d;
        end
    end

    assign bus.bus_data_out   = data_out_q;
    assign bus.bus_data_valid = data_valid_q;
    assign interrupt_req      = req_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: a vector table covering flag set,
// masking, clear-on-read and decode, plus hand sequences for multi-cycle cases.
module tb_interrupt_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;
    logic [3:0]  timer_evt;
    logic [1:0]  stopwatch_evt;
    logic        prog_timer_evt;
    logic        serial_evt;
    logic [3:0]  input_k0;
    logic [3:0]  input_k1;
    logic [14:0] interrupt_req;

    int checks = 0;
    int errors = 0;

    interrupt_controller_if bus_if ();

    interrupt_controller #(.BASE_ADDR(12'hF00)) dut (
        .clk            (clk),
        .reset          (reset),
        .clk_en         (clk_en),
        .timer_evt      (timer_evt),
        .stopwatch_evt  (stopwatch_evt),
        .prog_timer_evt (prog_timer_evt),
        .serial_evt     (serial_evt),
        .input_k0       (input_k0),
        .input_k1       (input_k1),
        .bus            (bus_if.slave),
        .interrupt_req  (interrupt_req)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  tim;
        logic [1:0]  sw;
        logic        pt;
        logic        sio;
        logic [3:0]  k0;
        logic [3:0]  k1;
        logic        we;
        logic        rd;
        logic [11:0] addr;
        logic [3:0]  wdata;
        logic        exp_valid;
        logic [3:0]  exp_data;
        logic [14:0] exp_req;
    } vec_t;

    localparam int NVEC = 31;
    vec_t vecs [NVEC];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        timer_evt             = '0;
        stopwatch_evt         = '0;
        prog_timer_evt        = 1'b0;
        serial_evt            = 1'b0;
        input_k0              = '0;
        input_k1              = '0;
        bus_if.bus_addr       = '0;
        bus_if.bus_write_en   = 1'b0;
        bus_if.bus_read_en    = 1'b0;
        bus_if.bus_data_in    = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [11:0] a, input logic [3:0] d);
        bus_if.bus_addr     = a;
        bus_if.bus_data_in  = d;
        bus_if.bus_write_en = 1'b1;
        cyc();
        bus_if.bus_write_en = 1'b0;
    endtask

    task automatic bus_read(input string nm, input logic [11:0] a, input logic [3:0] exp);
        bus_if.bus_addr    = a;
        bus_if.bus_read_en = 1'b1;
        cyc();
        bus_if.bus_read_en = 1'b0;
        check({nm, "_valid"}, 32'(bus_if.bus_data_valid), 32'd1);
        check({nm, "_data"}, 32'(bus_if.bus_data_out), 32'(exp));
    endtask

    initial begin
        // name, tim, sw, pt, sio, k0, k1, we, rd, addr, wdata, exp_valid, exp_data, exp_req
        vecs[0]  = '{"it_set_unmasked", 4'b0100, 2'b00, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 12'h000, 4'h0, 1'b0, 4'h0, 15'h0000};
        vecs[1]  = '{"eit_write",       4'b0000, 2'b00, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 12'hF10, 4'hF, 1'b0, 4'h0, 15'h0040};
        vecs[2]  = '{"it_read_clear",   4'b0000, 2'b00, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 12'hF00, 4'h0, 1'b1, 4'h4, 15'h0000};
        vecs[3]  = '{"eipt_write",      4'b0000, 2'b00, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 12'hF12, 4'h1, 1'b0, 4'h0, 15'h0000};
        vecs[4]  = '{"pt_pulse",        4'b0000, 2'b00, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 12'h000, 4'h0, 1'b0, 4'h0, 15'h0002};
        vecs[5]  = '{"ipt_read1",       4'b0000, 2'b00, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 12'hF02, 4'h0, 1'b1, 4'h1, 15'h0000};
        vecs[6]  = '{"ipt_read2",       4'b0000, 2'b00, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 12'hF02, 4'h0, 1'b1, 4'h0, 15'h0000};
        vecs[7]  = '{"eik0_write",      4'b0000, 2'b00, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 12'hF14, 4'h2, 1'b0, 4'h0, 15'h0000};
        vecs[8]  = '{"k0_masked_pin",   4'b0000, 2'b00, 1'b0, 1'b0, 4'h1, 4'h0, 1'b0, 1'b0, 12'h000, 4'h0, 1'b0, 4'h0, 15'h0000};
        vecs[9]  = '{"k0_enabled_pin",  4'b0000, 2'b00, 1'b0, 1'b0, 4'h2, 4'h0, 1'b0, 1'b0, 12'h000, 4'h0, 1'b0, 4'h0, 15'h0010};
        vecs[10] = '{"ik0_read",        4'b0000, 2'b00, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 12'hF04, 4'h0, 1'b1, 4'h1, 15'h0000};
        vecs[11] = '{"eik0_readback",   4'b0000, 2'b00, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 12'hF14, 4'h0, 1'b1, 4'h2, 15'h0000};
        vecs[12] = '{"factor_write_ign",4'b0000, 2'b00, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 12'hF00, 4'hF, 1'b0, 4'h0, 15'h0000};
        vecs[13] = '{"it_after_fwrite", 4'b0000, 2'b00, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 12'hF00, 4'h0, 1'b1, 4'h0, 15'h0000};
        vecs[14] = '{"sw_unmasked",     4'b0000, 2'b01, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 12'h000, 4'h0, 1'b0, 4'h0, 15'h0000};
        vecs[15] = '{"eisw_read0",      4'b0000, 2'b00, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 12'hF11, 4'h0, 1'b1, 4'h0, 15'h0000};
        vecs[16] = '{"eisw_write",      4'b0000, 2'b00, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 12'hF11, 4'hF, 1'b0, 4'h0, 15'h0020};
        vecs[17] = '{"isw_read",        4'b0000, 2'b00, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 12'hF01, 4'h0, 1'b1, 4'h1, 15'h0000};
        vecs[18] = '{"eisio_write",     4'b0000, 2'b00, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 12'hF13, 4'h1, 1'b0, 4'h0, 15'h0000};
        vecs[19] = '{"sio_pulse",       4'b0000, 2'b00, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 12'h000, 4'h0, 1'b0, 4'h0, 15'h0004};
        vecs[20] = '{"isio_read",       4'b0000, 2'b00, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 12'hF03, 4'h0, 1'b1, 4'h1, 15'h0000};
        vecs[21] = '{"eik1_write",      4'b0000, 2'b00, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 12'hF15, 4'hF, 1'b0, 4'h0, 15'h0000};
        vecs[22] = '{"k1_pulse",        4'b0000, 2'b00, 1'b0, 1'b0, 4'h0, 4'h8, 1'b0, 1'b0, 12'h000, 4'h0, 1'b0, 4'h0, 15'h0008};
        vecs[23] = '{"ik1_read",        4'b0000, 2'b00, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 12'hF05, 4'h0, 1'b1, 4'h1, 15'h0000};
        vecs[24] = '{"miss_f06",        4'b0000, 2'b00, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 12'hF06, 4'h0, 1'b0, 4'h0, 15'h0000};
        vecs[25] = '{"miss_f16",        4'b0000, 2'b00, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 12'hF16, 4'h0, 1'b0, 4'h0, 15'h0000};
        vecs[26] = '{"miss_eff",        4'b0000, 2'b00, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 12'hEFF, 4'h0, 1'b0, 4'h0, 15'h0000};
        vecs[27] = '{"eit_readback",    4'b0000, 2'b00, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 12'hF10, 4'h0, 1'b1, 4'hF, 15'h0000};
        vecs[28] = '{"eisw_readback",   4'b0000, 2'b00, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 12'hF11, 4'h0, 1'b1, 4'h3, 15'h0000};
        vecs[29] = '{"eisio_readback",  4'b0000, 2'b00, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 12'hF13, 4'h0, 1'b1, 4'h1, 15'h0000};
        vecs[30] = '{"eik1_readback",   4'b0000, 2'b00, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 12'hF15, 4'h0, 1'b1, 4'hF, 15'h0000};

        // Reset state
        idle_inputs();
        clk_en = 1'b1;
        reset  = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        check("rst_valid", 32'(bus_if.bus_data_valid), 32'd0);
        check("rst_data", 32'(bus_if.bus_data_out), 32'd0);
        check("rst_req", 32'(interrupt_req), 32'd0);

        // Vector table: one stimulus cycle, then one idle cycle to observe the request
        for (int i = 0; i < NVEC; i++) begin
            timer_evt           = vecs[i].tim;
            stopwatch_evt       = vecs[i].sw;
            prog_timer_evt      = vecs[i].pt;
            serial_evt          = vecs[i].sio;
            input_k0            = vecs[i].k0;
            input_k1            = vecs[i].k1;
            bus_if.bus_addr     = vecs[i].addr;
            bus_if.bus_write_en = vecs[i].we;
            bus_if.bus_read_en  = vecs[i].rd;
            bus_if.bus_data_in  = vecs[i].wdata;
            cyc();
            idle_inputs();
            check({vecs[i].name, "_valid"}, 32'(bus_if.bus_data_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid)
                check({vecs[i].name, "_data"}, 32'(bus_if.bus_data_out), 32'(vecs[i].exp_data));
            cyc();
            check({vecs[i].name, "_req"}, 32'(interrupt_req), 32'(vecs[i].exp_req));
        end

        // Event coincident with clearing read: old value returned, new bit survives
        timer_evt = 4'b1000;
        cyc();
        timer_evt          = 4'b0001;
        bus_if.bus_addr    = 12'hF00;
        bus_if.bus_read_en = 1'b1;
        cyc();
        idle_inputs();
        check("coinc_valid", 32'(bus_if.bus_data_valid), 32'd1);
        check("coinc_data", 32'(bus_if.bus_data_out), 32'h8);
        bus_read("coinc_after", 12'hF00, 4'h1);
        bus_read("coinc_cleared", 12'hF00, 4'h0);
        cyc();
        check("coinc_req", 32'(interrupt_req), 32'd0);

        // clk_en low freezes flags, masks and reads
        clk_en              = 1'b0;
        timer_evt           = 4'hF;
        stopwatch_evt       = 2'b11;
        bus_if.bus_addr     = 12'hF10;
        bus_if.bus_data_in  = 4'h0;
        bus_if.bus_write_en = 1'b1;
        cyc();
        idle_inputs();
        bus_if.bus_addr    = 12'hF00;
        bus_if.bus_read_en = 1'b1;
        cyc();
        idle_inputs();
        check("clken_lo_valid", 32'(bus_if.bus_data_valid), 32'd0);
        clk_en = 1'b1;
        bus_read("clken_lo_it", 12'hF00, 4'h0);
        bus_read("clken_lo_isw", 12'hF01, 4'h0);
        bus_read("clken_lo_eit", 12'hF10, 4'hF);

        // Everything set, then reset during an in-flight read
        bus_write(12'hF10, 4'hF);
        bus_write(12'hF11, 4'hF);
        bus_write(12'hF12, 4'hF);
        bus_write(12'hF13, 4'hF);
        bus_write(12'hF14, 4'hF);
        bus_write(12'hF15, 4'hF);
        timer_evt      = 4'hF;
        stopwatch_evt  = 2'b11;
        prog_timer_evt = 1'b1;
        serial_evt     = 1'b1;
        input_k0       = 4'hF;
        input_k1       = 4'hF;
        cyc();
        idle_inputs();
        cyc();
`ifndef INT_INPUT_EDGE_EN
        check("all_set_req", 32'(interrupt_req), 32'h007E);
`endif
        bus_if.bus_addr    = 12'hF10;
        bus_if.bus_read_en = 1'b1;
        reset              = 1'b1;
        cyc();
        reset = 1'b0;
        idle_inputs();
        check("midrst_valid", 32'(bus_if.bus_data_valid), 32'd0);
        check("midrst_data", 32'(bus_if.bus_data_out), 32'd0);
        check("midrst_req", 32'(interrupt_req), 32'd0);
        for (int a = 0; a < 6; a++) begin
            bus_read($sformatf("post_rst_f%0d", a), 12'hF00 + 12'(a), 4'h0);
            bus_read($sformatf("post_rst_m%0d", a), 12'hF10 + 12'(a), 4'h0);
        end
        cyc();
        check("post_rst_req", 32'(interrupt_req), 32'd0);

`ifdef INT_INPUT_EDGE_EN
        // Held-high pins produce exactly one edge event
        bus_write(12'hF15, 4'hF);
        input_k1 = 4'hF;
        cyc();
        cyc();
        check("edge_req_early", 32'(interrupt_req[3]), 32'd0);
        cyc();
        cyc();
        check("edge_req_set", 32'(interrupt_req[3]), 32'd1);
        for (int c = 0; c < 6; c++) cyc();
        bus_read("edge_ik1_once", 12'hF05, 4'h1);
        for (int c = 0; c < 3; c++) cyc();
        bus_read("edge_ik1_stays0", 12'hF05, 4'h0);
        input_k1 = 4'h0;
        cyc();
        check("edge_req_clear", 32'(interrupt_req[3]), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
